// File: rtl/magnitude_estimator_stream_pkg.sv
// Shared types and constants for the streaming magnitude estimator.
// Estimator mode encodings travel with each sample.
package magnitude_estimator_stream_pkg;

    typedef enum logic [1:0] {
        MODE_AB375 = 2'd0,  // max + 0.375*min
        MODE_AB500 = 2'd1,  // max + 0.5*min
        MODE_AB_HQ = 2'd2,  // 15/16*max + 15/32*min
        MODE_LINF  = 2'd3   // max only
    } mode_e;

    localparam int MODE_WIDTH = 2;

endpackage

// File: rtl/magnitude_estimator_stream_if.sv
// Stream bundle for the magnitude estimator: sample input, magnitude output and frame-peak report.
interface magnitude_estimator_stream_if #(
    parameter int DATA_WIDTH  = 24,
    parameter int OUT_WIDTH   = 24,
    parameter int INDEX_WIDTH = 10
);
    import magnitude_estimator_stream_pkg::*;

    logic                     i_valid;
    logic                     o_ready;
    logic [2*DATA_WIDTH-1:0]  i_fft_complex;
    logic [INDEX_WIDTH-1:0]   i_index;
    logic                     i_last;
    logic [MODE_WIDTH-1:0]    i_mode;
    logic                     o_valid;
    logic                     i_ready;
    logic [OUT_WIDTH-1:0]     o_magnitude;
    logic [INDEX_WIDTH-1:0]   o_index;
    logic                     o_last;
    logic                     o_peak_valid;
    logic [OUT_WIDTH-1:0]     o_peak_magnitude;
    logic [INDEX_WIDTH-1:0]   o_peak_index;

    modport slave (
        input  i_valid, i_fft_complex, i_index, i_last, i_mode, i_ready,
        output o_ready, o_valid, o_magnitude, o_index, o_last,
               o_peak_valid, o_peak_magnitude, o_peak_index
    );

    modport master (
        output i_valid, i_fft_complex, i_index, i_last, i_mode, i_ready,
        input  o_ready, o_valid, o_magnitude, o_index, o_last,
               o_peak_valid, o_peak_magnitude, o_peak_index
    );

endinterface

// File: rtl/magnitude_estimator_stream_peak_tracker.sv
// Per-frame peak tracker: keeps the earliest strictly-largest magnitude of a frame and
// reports it with a one-cycle pulse after the frame's last beat is transferred.
module mag_peak_tracker #(
    parameter int OUT_WIDTH   = 24,
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   beat,
    input  logic [OUT_WIDTH-1:0]   magnitude,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic                   last,
    output logic                   o_peak_valid,
    output logic [OUT_WIDTH-1:0]   o_peak_magnitude,
    output logic [INDEX_WIDTH-1:0] o_peak_index
);

    logic                   in_frame;
    logic [OUT_WIDTH-1:0]   acc_mag;
    logic [INDEX_WIDTH-1:0] acc_idx;
    logic                   take_new;
    logic [OUT_WIDTH-1:0]   cand_mag;
    logic [INDEX_WIDTH-1:0] cand_idx;

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        take_new = !in_frame || (magnitude > acc_mag);
        cand_mag = take_new ? magnitude : acc_mag;
        cand_idx = take_new ? index     : acc_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_frame         <= 1'b0;
            acc_mag          <= '0;
            acc_idx          <= '0;
            o_peak_valid     <= 1'b0;
            o_peak_magnitude <= '0;
            o_peak_index     <= '0;
        end else begin
            o_peak_valid <= 1'b0;
            if (beat) begin
                if (last) begin
                    o_peak_magnitude <= cand_mag;
                    o_peak_index     <= cand_idx;
                    o_peak_valid     <= 1'b1;
                    in_frame         <= 1'b0;
                end else begin
                    acc_mag  <= cand_mag;
                    acc_idx  <= cand_idx;
                    in_frame <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/magnitude_estimator_stream.sv
// Streaming alpha-max-plus-beta-min magnitude estimator: 3-stage pipeline with a global
// stall, per-sample mode, index/last sideband and a per-frame peak report.
module magnitude_estimator_stream
    import magnitude_estimator_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int OUT_WIDTH   = 24,
    parameter int INDEX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    magnitude_estimator_stream_if.slave  stream
);

    localparam int SUM_WIDTH = DATA_WIDTH + 1;

    logic en;
    logic [DATA_WIDTH-1:0] re_bits, im_bits, abs_re, abs_im;

    logic                   s1_valid, s1_last;
    logic [DATA_WIDTH-1:0]  s1_abs_re, s1_abs_im;
    logic [INDEX_WIDTH-1:0] s1_index;
    mode_e                  s1_mode;

    logic                   s2_valid, s2_last;
    logic [DATA_WIDTH-1:0]  s2_max, s2_min;
    logic [INDEX_WIDTH-1:0] s2_index;
    mode_e                  s2_mode;

    logic                   out_valid, out_last;
    logic [OUT_WIDTH-1:0]   out_mag;
    logic [INDEX_WIDTH-1:0] out_index;

    logic [SUM_WIDTH-1:0]   mx, mn, sum;
    logic [OUT_WIDTH-1:0]   sat_mag;

    logic                   peak_valid;
    logic [OUT_WIDTH-1:0]   peak_mag;
    logic [INDEX_WIDTH-1:0] peak_idx;

    // The whole pipeline moves as one; a held output freezes every stage behind it.
    assign en             = !out_valid || stream.i_ready;
    assign stream.o_ready = en;

    // Unsigned absolute value in DATA_WIDTH bits: the most negative input maps to 2^(DW-1).
    assign re_bits = stream.i_fft_complex[2*DATA_WIDTH-1:DATA_WIDTH];
    assign im_bits = stream.i_fft_complex[DATA_WIDTH-1:0];
    assign abs_re  = re_bits[DATA_WIDTH-1] ? (~re_bits + DATA_WIDTH'(1)) : re_bits;
    assign abs_im  = im_bits[DATA_WIDTH-1] ? (~im_bits + DATA_WIDTH'(1)) : im_bits;

    // NOTE: clocked state uses non-blocking assignments so every stage samples pre-edge values.
    // NOTE: datapath registers are reset as well so outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            s1_index  <= '0;
            s1_mode   <= MODE_AB375;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_max    <= '0;
            s2_min    <= '0;
            s2_index  <= '0;
            s2_mode   <= MODE_AB375;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_mag   <= '0;
            out_index <= '0;
        end else if (en) begin
            s1_valid  <= stream.i_valid;
            s1_last   <= stream.i_last;
            s1_abs_re <= abs_re;
            s1_abs_im <= abs_im;
            s1_index  <= stream.i_index;
            s1_mode   <= mode_e'(stream.i_mode);

            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_max    <= (s1_abs_re >= s1_abs_im) ? s1_abs_re : s1_abs_im;
            s2_min    <= (s1_abs_re >= s1_abs_im) ? s1_abs_im : s1_abs_re;
            s2_index  <= s1_index;
            s2_mode   <= s1_mode;

            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_mag   <= sat_mag;
            out_index <= s2_index;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mx  = {1'b0, s2_max};
        mn  = {1'b0, s2_min};
        sum = '0;
        case (s2_mode)
            MODE_AB375: sum = mx + (mn >> 2) + (mn >> 3);
            MODE_AB500: sum = mx + (mn >> 1);
            MODE_AB_HQ: sum = (mx - (mx >> 4)) + ((mn >> 1) - (mn >> 5));
            MODE_LINF:  sum = mx;
            default:    sum = mx;
        endcase
        sat_mag = (|sum[SUM_WIDTH-1:OUT_WIDTH]) ? '1 : sum[OUT_WIDTH-1:0];
    end

    mag_peak_tracker #(
        .OUT_WIDTH   (OUT_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_peak (
        .clk              (clk),
        .reset_n          (reset_n),
        .beat             (out_valid && stream.i_ready),
        .magnitude        (out_mag),
        .index            (out_index),
        .last             (out_last),
        .o_peak_valid     (peak_valid),
        .o_peak_magnitude (peak_mag),
        .o_peak_index     (peak_idx)
    );

    assign stream.o_valid          = out_valid;
    assign stream.o_magnitude      = out_mag;
    assign stream.o_index          = out_index;
    assign stream.o_last           = out_last;
    assign stream.o_peak_valid     = peak_valid;
    assign stream.o_peak_magnitude = peak_mag;
    assign stream.o_peak_index     = peak_idx;

endmodule

// File: tb/tb_magnitude_estimator_stream.sv
// Directed bench for magnitude_estimator_stream: modes, boundaries, saturation,
// backpressure, frame peak and mid-frame reset.
module tb_magnitude_estimator_stream;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    magnitude_estimator_stream_if #(.DATA_WIDTH(24), .OUT_WIDTH(24), .INDEX_WIDTH(10)) if24 ();
    magnitude_estimator_stream_if #(.DATA_WIDTH(24), .OUT_WIDTH(23), .INDEX_WIDTH(10)) if23 ();

    magnitude_estimator_stream #(.DATA_WIDTH(24), .OUT_WIDTH(24), .INDEX_WIDTH(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stream  (if24)
    );

    magnitude_estimator_stream #(.DATA_WIDTH(24), .OUT_WIDTH(23), .INDEX_WIDTH(10)) dut23 (
        .clk     (clk),
        .reset_n (reset_n),
        .stream  (if23)
    );

    always #5 clk = ~clk;

    task automatic drive24(int re, int im, int mode, int idx, logic last, logic valid);
        if24.i_valid       = valid;
        if24.i_fft_complex = {re[23:0], im[23:0]};
        if24.i_index       = idx[9:0];
        if24.i_last        = last;
        if24.i_mode        = mode[1:0];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive24(0, 0, 0, 0, 1'b0, 1'b0);
        if24.i_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One sample through an idle pipeline; output must appear on the third edge counting the accept.
    task automatic single24(int re, int im, int mode, int exp, string name);
        @(negedge clk);
        drive24(re, im, mode, 0, 1'b0, 1'b1);
        if24.i_ready = 1'b1;
        #1;
        checks++;
        if (if24.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: o_ready=%b expected=1", name, if24.o_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if24.i_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if24.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early: o_valid=%b expected=0", name, if24.o_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if24.o_valid !== 1'b1 || if24.o_magnitude !== 24'(exp)) begin
            failures++;
            $display("FAIL %s mode=%0d: o_valid=%b o_magnitude=%0d expected=%0d",
                     name, mode, if24.o_valid, if24.o_magnitude, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if24.o_valid !== 1'b0 || if24.o_magnitude !== 24'd0 || if24.o_index !== 10'd0 ||
            if24.o_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: valid=%b mag=%0d idx=%0d last=%b expected all 0",
                     if24.o_valid, if24.o_magnitude, if24.o_index, if24.o_last);
        end
        checks++;
        if (if24.o_peak_valid !== 1'b0 || if24.o_peak_magnitude !== 24'd0 || if24.o_peak_index !== 10'd0) begin
            failures++;
            $display("FAIL reset_peak: pv=%b pmag=%0d pidx=%0d expected all 0",
                     if24.o_peak_valid, if24.o_peak_magnitude, if24.o_peak_index);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (if24.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: o_ready=%b expected=1", if24.o_ready);
        end
    endtask

    task automatic test_modes();
        int exp_mag[4] = '{5125, 5500, 5157, 4000};
        for (int m = 0; m < 4; m++) single24(3000, -4000, m, exp_mag[m], "modes");
    endtask

    task automatic test_boundary();
        single24(-8388608, 0, 0, 8388608, "most_negative");
        single24(0, 0, 0, 0, "zero");
    endtask

    task automatic test_saturation();
        int modes[2] = '{0, 3};
        int exps[2]  = '{8388607, 8000000};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if23.i_valid       = 1'b1;
            if23.i_fft_complex = {24'(8000000), 24'(8000000)};
            if23.i_index       = 10'd0;
            if23.i_last        = 1'b0;
            if23.i_mode        = 2'(modes[k]);
            @(posedge clk);
            @(negedge clk);
            if23.i_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (if23.o_valid !== 1'b1 || if23.o_magnitude !== 23'(exps[k])) begin
                failures++;
                $display("FAIL saturation mode=%0d: o_valid=%b o_magnitude=%0d expected=%0d",
                         modes[k], if23.o_valid, if23.o_magnitude, exps[k]);
            end
        end
    endtask

    // 8 samples in mode 1, i_ready low on cycles 5..7: expected magnitude 115*k+100, index k+16.
    task automatic test_backpressure();
        int sent = 0;
        int rcv = 0;
        int low_cycles = 0;
        logic stall;
        logic [23:0] held_mag;
        logic [9:0]  held_idx;
        logic acc, out;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            stall = (c >= 5 && c <= 7);
            if24.i_ready = !stall;
            drive24(100 * (sent + 1), -30 * sent, 1, sent + 16, 1'b0, sent < 8);
            #1;
            checks++;
            if (if24.o_ready !== !stall) begin
                failures++;
                $display("FAIL bp_ready cycle=%0d: o_ready=%b expected=%b", c, if24.o_ready, !stall);
            end
            if (!if24.o_ready) low_cycles++;
            if (c == 5) begin
                held_mag = if24.o_magnitude;
                held_idx = if24.o_index;
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (if24.o_valid !== 1'b1 || if24.o_magnitude !== held_mag || if24.o_index !== held_idx) begin
                    failures++;
                    $display("FAIL bp_hold cycle=%0d: valid=%b mag=%0d idx=%0d expected held mag=%0d idx=%0d",
                             c, if24.o_valid, if24.o_magnitude, if24.o_index, held_mag, held_idx);
                end
            end
            acc = if24.i_valid && if24.o_ready;
            out = if24.o_valid && if24.i_ready;
            if (out) begin
                checks++;
                if (if24.o_magnitude !== 24'(115 * rcv + 100) || if24.o_index !== 10'(rcv + 16)) begin
                    failures++;
                    $display("FAIL bp_order beat=%0d: mag=%0d idx=%0d expected mag=%0d idx=%0d",
                             rcv, if24.o_magnitude, if24.o_index, 115 * rcv + 100, rcv + 16);
                end
                rcv++;
            end
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        drive24(0, 0, 0, 0, 1'b0, 1'b0);
        if24.i_ready = 1'b1;
        checks++;
        if (rcv != 8 || sent != 8 || low_cycles != 3) begin
            failures++;
            $display("FAIL bp_count: received=%0d sent=%0d ready_low=%0d expected 8 8 3", rcv, sent, low_cycles);
        end
    endtask

    // Runs one frame in mode 3 (magnitude = |Re|) and checks the single peak pulse timing and value.
    task automatic run_frame(int n, int m0, int m1, int m2, int m3, int exp_mag, int exp_idx, string name);
        int mags[4];
        int sent = 0;
        int pulses = 0;
        int last_cycle = -10;
        int pulse_cycle = -20;
        logic acc;
        mags = '{m0, m1, m2, m3};
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (sent < n) drive24(mags[sent], 0, 3, sent, sent == n - 1, 1'b1);
            else          drive24(0, 0, 3, 0, 1'b0, 1'b0);
            #1;
            if (if24.o_peak_valid) begin
                pulses++;
                pulse_cycle = c;
            end
            if (if24.o_valid && if24.i_ready && if24.o_last) last_cycle = c;
            acc = if24.i_valid && if24.o_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        checks++;
        if (pulses != 1 || pulse_cycle != last_cycle + 1) begin
            failures++;
            $display("FAIL %s pulse: pulses=%0d at cycle %0d, last transfer cycle %0d, expected 1 pulse one cycle later",
                     name, pulses, pulse_cycle, last_cycle);
        end
        checks++;
        if (if24.o_peak_magnitude !== 24'(exp_mag) || if24.o_peak_index !== 10'(exp_idx)) begin
            failures++;
            $display("FAIL %s value: peak_mag=%0d peak_idx=%0d expected %0d %0d",
                     name, if24.o_peak_magnitude, if24.o_peak_index, exp_mag, exp_idx);
        end
    endtask

    task automatic test_peak();
        pulse_reset();
        run_frame(4, 10, 50, 50, 20, 50, 1, "peak_frame");
        run_frame(1, 77, 0, 0, 0, 77, 0, "peak_single");
    endtask

    task automatic test_midreset();
        if24.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive24(900 - 50 * k, 0, 3, k, 1'b0, 1'b1);
            @(posedge clk);
        end
        #1;
        checks++;
        if (if24.o_valid !== 1'b1 || if24.o_magnitude !== 24'd900) begin
            failures++;
            $display("FAIL midreset_pre: valid=%b mag=%0d expected 1 900", if24.o_valid, if24.o_magnitude);
        end
        #2;
        reset_n = 1'b0;
        drive24(0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++;
        if (if24.o_valid !== 1'b0 || if24.o_magnitude !== 24'd0 || if24.o_peak_magnitude !== 24'd0 ||
            if24.o_peak_index !== 10'd0 || if24.o_peak_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: valid=%b mag=%0d pmag=%0d pidx=%0d pv=%b expected all 0",
                     if24.o_valid, if24.o_magnitude, if24.o_peak_magnitude, if24.o_peak_index, if24.o_peak_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(3, 30, 70, 40, 0, 70, 1, "midreset_frame");
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        checks   = 0;
        failures = 0;
        drive24(0, 0, 0, 0, 1'b0, 1'b0);
        if24.i_ready       = 1'b1;
        if23.i_valid       = 1'b0;
        if23.i_fft_complex = '0;
        if23.i_index       = '0;
        if23.i_last        = 1'b0;
        if23.i_mode        = '0;
        if23.i_ready       = 1'b1;

        test_reset();
        test_modes();
        test_boundary();
        test_saturation();
        test_backpressure();
        test_peak();
        test_midreset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
